// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage controller for the pipelined MIPS core. It selects the next PC
// source, gates the PC and IF/ID register loads, and issues IF/ID and ID/EX
// flushes. It arbitrates between branch, jump-register, jump, load-use stall
// and instruction-memory wait conditions. Two saturating counters record
// stall and flush cycles for performance inspection.
//
// Parameters:
//   RESET_WAIT   idle cycles spent in BOOT after reset release (0..15)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk             system clock, rising-edge active
//   rst             asynchronous active-high reset
//   imem_ready_i    instruction memory returns the requested word this cycle
//   fetch_req_o     fetch request for the current PC
//   branch_taken_i  branch resolved taken in EX
//   jr_i            jump-register decoded in ID
//   jump_i          J/JAL decoded in ID
//   load_use_i      load-use hazard detected in ID
//   halt_i          halt request decoded in ID
//   PCSrc           next-PC select: 00 PC+4, 01 branch, 10 jump, 11 jr
//   pc_en_o         PC register write enable
//   ifid_en_o       IF/ID register load enable
//   ifid_flush_o    IF/ID clear to bubble
//   idex_flush_o    ID/EX clear to bubble
//   stall_cnt_o     cycles with pc_en_o=0 while in RUN or WAIT_MEM
//   flush_cnt_o     cycles with ifid_flush_o=1
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int RESET_WAIT = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready_i,
  output logic             fetch_req_o,
  input  logic             branch_taken_i,
  input  logic             jr_i,
  input  logic             jump_i,
  input  logic             load_use_i,
  input  logic             halt_i,
  output logic [1:0]       PCSrc,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'b00,
    ST_RUN      = 2'b01,
    ST_WAIT_MEM = 2'b10,
    ST_HALTED   = 2'b11
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             discard_r;
  logic             discard_nxt_s;
  logic             halt_pend_r;
  logic             halt_pend_nxt_s;
  logic [3:0]       boot_cnt_r;
  logic             boot_done_s;
  logic             redirect_s;
  logic             active_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // BOOT ends on the edge that closes the RESET_WAIT-th idle cycle; with a
  // wait of 0 or 1 that is the first edge after reset release.
  assign boot_done_s = (({1'b0, boot_cnt_r} + 5'd1) >= 5'(RESET_WAIT));
  assign redirect_s  = branch_taken_i | jr_i | jump_i;
  assign active_s    = (state_r == ST_RUN) || (state_r == ST_WAIT_MEM);

  assign stall_cnt_o = stall_cnt_r;
  assign flush_cnt_o = flush_cnt_r;

  // State and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_BOOT;
      discard_r   <= 1'b0;
      halt_pend_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      discard_r   <= discard_nxt_s;
      halt_pend_r <= halt_pend_nxt_s;
    end
  end

  // Post-reset idle counter, advancing only while waiting in BOOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      boot_cnt_r <= 4'd0;
    end else if ((state_r == ST_BOOT) && !boot_done_s) begin
      boot_cnt_r <= boot_cnt_r + 4'd1;
    end else begin
      boot_cnt_r <= boot_cnt_r;
    end
  end

  // Next-state, flag update and combinational control outputs.
  always_comb begin
    state_nxt_s     = state_r;
    discard_nxt_s   = discard_r;
    halt_pend_nxt_s = halt_pend_r;
    fetch_req_o     = 1'b0;
    PCSrc           = 2'b00;
    pc_en_o         = 1'b0;
    ifid_en_o       = 1'b0;
    ifid_flush_o    = 1'b0;
    idex_flush_o    = 1'b0;

    case (state_r)
      ST_BOOT: begin
        if (boot_done_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_BOOT;
        end
      end

      ST_RUN, ST_WAIT_MEM: begin
        fetch_req_o = 1'b1;
        if (redirect_s) begin
          // The PC takes the target on this edge regardless of memory
          // readiness; a word still in flight for the old PC must be dropped.
          pc_en_o      = 1'b1;
          ifid_flush_o = 1'b1;
          if (branch_taken_i) begin
            PCSrc        = 2'b01;
            idex_flush_o = 1'b1;
          end else if (jr_i) begin
            PCSrc = 2'b11;
          end else begin
            PCSrc = 2'b10;
          end
          if (imem_ready_i) begin
            discard_nxt_s = 1'b0;
            state_nxt_s   = ST_RUN;
          end else begin
            discard_nxt_s = 1'b1;
            state_nxt_s   = ST_WAIT_MEM;
          end
        end else if (load_use_i) begin
          // Hold PC and IF/ID, insert one bubble into EX.
          idex_flush_o = 1'b1;
        end else if (halt_pend_r || halt_i) begin
          if (imem_ready_i) begin
            // A halt that waited on memory (or a stale returning word) leaves
            // a fetched word behind that must not reach ID.
            if (halt_pend_r || discard_r || (state_r == ST_WAIT_MEM)) begin
              ifid_flush_o = 1'b1;
            end else begin
              ifid_flush_o = 1'b0;
            end
            halt_pend_nxt_s = 1'b0;
            discard_nxt_s   = 1'b0;
            state_nxt_s     = ST_HALTED;
          end else begin
            halt_pend_nxt_s = 1'b1;
            state_nxt_s     = ST_WAIT_MEM;
          end
        end else if (imem_ready_i) begin
          if (discard_r) begin
            // Word returned for the pre-redirect PC: turn it into a bubble.
            ifid_flush_o  = 1'b1;
            discard_nxt_s = 1'b0;
          end else begin
            pc_en_o   = 1'b1;
            ifid_en_o = 1'b1;
          end
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT_MEM;
        end
      end

      ST_HALTED: begin
        state_nxt_s = ST_HALTED;
      end

      default: begin
        state_nxt_s     = ST_BOOT;
        discard_nxt_s   = 1'b0;
        halt_pend_nxt_s = 1'b0;
      end
    endcase
  end

  // Saturating stall counter: PC held while the fetch path is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (active_s && !pc_en_o && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Saturating flush counter: cycles that clear IF/ID.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_r <= '0;
    end else if (ifid_flush_o && (flush_cnt_r != {CNT_W{1'b1}})) begin
      flush_cnt_r <= flush_cnt_r + CNT_W'(1);
    end else begin
      flush_cnt_r <= flush_cnt_r;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl. Each step drives one cycle of inputs and
// queues the outputs expected for that cycle; they are popped and compared at
// the following falling edge. Stall and flush counters are tracked by a small
// bench-side model. A second instance with CNT_W=4 exercises saturation.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  typedef struct {
    string      tag;
    logic       fetch;
    logic [1:0] pcsrc;
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
  } exp_t;

  // Expected output vectors {fetch, PCSrc[1:0], pc_en, ifid_en, ifid_flush, idex_flush}
  localparam logic [6:0] E_ZERO = 7'b0_00_0_0_0_0;
  localparam logic [6:0] E_NORM = 7'b1_00_1_1_0_0;
  localparam logic [6:0] E_BR   = 7'b1_01_1_0_1_1;
  localparam logic [6:0] E_JR   = 7'b1_11_1_0_1_0;
  localparam logic [6:0] E_JP   = 7'b1_10_1_0_1_0;
  localparam logic [6:0] E_LU   = 7'b1_00_0_0_0_1;
  localparam logic [6:0] E_STL  = 7'b1_00_0_0_0_0;
  localparam logic [6:0] E_DISC = 7'b1_00_0_0_1_0;

  logic        clk;
  logic        rst;
  logic        imem_ready;
  logic        branch_taken;
  logic        jr;
  logic        jump;
  logic        load_use;
  logic        halt;
  logic        fetch_req;
  logic [1:0]  pcsrc;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        rst_sm;
  logic        ready_sm;
  logic        zero_sm;
  logic        fetch_req_sm;
  logic [1:0]  pcsrc_sm;
  logic        pc_en_sm;
  logic        ifid_en_sm;
  logic        ifid_flush_sm;
  logic        idex_flush_sm;
  logic [3:0]  stall_cnt_sm;
  logic [3:0]  flush_cnt_sm;

  int          checks;
  int          failures;
  int          m_stall;
  int          m_flush;
  int          m_sat;
  exp_t        sb_q[$];

  fetch_ctrl #(.RESET_WAIT(2), .CNT_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_ready_i   (imem_ready),
    .fetch_req_o    (fetch_req),
    .branch_taken_i (branch_taken),
    .jr_i           (jr),
    .jump_i         (jump),
    .load_use_i     (load_use),
    .halt_i         (halt),
    .PCSrc          (pcsrc),
    .pc_en_o        (pc_en),
    .ifid_en_o      (ifid_en),
    .ifid_flush_o   (ifid_flush),
    .idex_flush_o   (idex_flush),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  fetch_ctrl #(.RESET_WAIT(2), .CNT_W(4)) dut_sm (
    .clk            (clk),
    .rst            (rst_sm),
    .imem_ready_i   (ready_sm),
    .fetch_req_o    (fetch_req_sm),
    .branch_taken_i (zero_sm),
    .jr_i           (zero_sm),
    .jump_i         (zero_sm),
    .load_use_i     (zero_sm),
    .halt_i         (zero_sm),
    .PCSrc          (pcsrc_sm),
    .pc_en_o        (pc_en_sm),
    .ifid_en_o      (ifid_en_sm),
    .ifid_flush_o   (ifid_flush_sm),
    .idex_flush_o   (idex_flush_sm),
    .stall_cnt_o    (stall_cnt_sm),
    .flush_cnt_o    (flush_cnt_sm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive {ready, branch, jr, jump, load_use, halt}, queue the
  // expected outputs, compare at the falling edge, then advance the model.
  task automatic step(input string tag, input logic [5:0] in_v, input logic [6:0] ex_v);
    exp_t e;
    {imem_ready, branch_taken, jr, jump, load_use, halt} = in_v;
    e.tag        = tag;
    e.fetch      = ex_v[6];
    e.pcsrc      = ex_v[5:4];
    e.pc_en      = ex_v[3];
    e.ifid_en    = ex_v[2];
    e.ifid_flush = ex_v[1];
    e.idex_flush = ex_v[0];
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({e.tag, ".fetch"},      16'(fetch_req),  16'(e.fetch));
    chk({e.tag, ".pcsrc"},      16'(pcsrc),      16'(e.pcsrc));
    chk({e.tag, ".pc_en"},      16'(pc_en),      16'(e.pc_en));
    chk({e.tag, ".ifid_en"},    16'(ifid_en),    16'(e.ifid_en));
    chk({e.tag, ".ifid_flush"}, 16'(ifid_flush), 16'(e.ifid_flush));
    chk({e.tag, ".idex_flush"}, 16'(idex_flush), 16'(e.idex_flush));
    chk({e.tag, ".stall_cnt"},  stall_cnt,       16'(m_stall));
    chk({e.tag, ".flush_cnt"},  flush_cnt,       16'(m_flush));
    if (!rst) begin
      if (e.fetch && !e.pc_en) m_stall++;
      if (e.ifid_flush) m_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string tag);
    rst     = 1'b1;
    m_stall = 0;
    m_flush = 0;
    step(tag, 6'b100000, E_ZERO);
    rst = 1'b0;
    step({tag, ".boot0"}, 6'b100000, E_ZERO);
    step({tag, ".boot1"}, 6'b100000, E_ZERO);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    m_stall  = 0;
    m_flush  = 0;
    rst      = 1'b1;
    rst_sm   = 1'b1;
    ready_sm = 1'b0;
    zero_sm  = 1'b0;
    {imem_ready, branch_taken, jr, jump, load_use, halt} = 6'b000000;
    @(posedge clk);
    #1;

    // Reset state, boot delay, then steady fetch with memory always ready.
    reset_pulse("boot");
    for (int i = 0; i < 10; i++) step("run", 6'b100000, E_NORM);

    // Simultaneous redirects and hazard priority.
    step("br_and_jump", 6'b110100, E_BR);
    step("after_br",    6'b100000, E_NORM);
    step("br_and_lu",   6'b110010, E_BR);
    step("jr",          6'b101000, E_JR);
    step("jump",        6'b100100, E_JP);
    step("load_use",    6'b100010, E_LU);
    step("after_lu",    6'b100000, E_NORM);

    // Memory wait with a jr landing in the middle of it.
    step("wait1",       6'b000000, E_STL);
    step("wait2_jr",    6'b001000, E_JR);
    step("wait3",       6'b000000, E_STL);
    step("ready_disc",  6'b100000, E_DISC);
    step("after_disc",  6'b100000, E_NORM);

    // Halt while waiting on memory, then HALTED ignores everything.
    step("hw_wait",     6'b000000, E_STL);
    step("hw_halt",     6'b000001, E_STL);
    step("hw_pend",     6'b000000, E_STL);
    step("hw_ready",    6'b100000, E_DISC);
    step("halted0",     6'b110101, E_ZERO);
    step("halted1",     6'b100000, E_ZERO);

    // Reset out of HALTED; then reset must also clear a pending discard.
    reset_pulse("rst_halt");
    step("disc_set",    6'b001000, E_JR);
    reset_pulse("rst_disc");
    step("disc_clear",  6'b100000, E_NORM);

    // Halt in RUN with memory ready: straight to HALTED with no flush.
    step("halt_run",    6'b100001, E_STL);
    step("halted2",     6'b100000, E_ZERO);

    // Narrow counter: continuous memory wait saturates at 15 and holds.
    rst_sm = 1'b0;
    m_sat  = 0;
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      chk("sat_stall", 16'(stall_cnt_sm), 16'(m_sat));
      chk("sat_flush", 16'(flush_cnt_sm), 16'd0);
      if (k >= 2 && m_sat < 15) m_sat++;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-stage controller for the pipelined MIPS core. It drives the program counter's next-address select and write enable, and the IF/ID and ID/EX pipeline register enables and flushes. It arbitrates between branch, jump, jump-register, load-use stall and instruction-memory wait conditions. It also keeps saturating stall and flush counters for performance inspection.

## Interface
- `RESET_WAIT`, default 2: number of idle cycles after reset release before the first fetch (0..15).
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `imem_ready_i`  in  1  instruction memory returns the requested word this cycle.
- `fetch_req_o`  out  1  instruction fetch request for the current PC.
- `branch_taken_i`  in  1  branch resolved taken in EX.
- `jr_i`  in  1  jump-register decoded in ID.
- `jump_i`  in  1  J/JAL decoded in ID.
- `load_use_i`  in  1  load-use hazard detected in ID.
- `halt_i`  in  1  halt request decoded in ID.
- `PCSrc`  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target, 11 jr target.
- `pc_en_o`  out  1  PC register write enable.
- `ifid_en_o`  out  1  IF/ID register load enable.
- `ifid_flush_o`  out  1  IF/ID clear to bubble.
- `idex_flush_o`  out  1  ID/EX clear to bubble.
- `stall_cnt_o`  out  CNT_W  cycles with `pc_en_o`=0 while in RUN or WAIT_MEM.
- `flush_cnt_o`  out  CNT_W  cycles with `ifid_flush_o`=1.

## Operation
- States: BOOT, RUN, WAIT_MEM, HALTED. Internal flags: `discard`, `halt_pend`.
- Outputs are combinational from the state, the flags and the current inputs. The state, flags and counters are registered.
- **BOOT**
  - `fetch_req_o`=0; all enables and flushes are 0.
  - A counter runs for `RESET_WAIT` cycles, then the block moves to RUN.
  - With `RESET_WAIT`=0, the block enters RUN on the first edge after reset release.
- **RUN and WAIT_MEM**
  - `fetch_req_o`=1.
  - Per-cycle priority: branch_taken > jr > jump > load_use > normal.
- **branch_taken**: `PCSrc`=01, `pc_en_o`=1, `ifid_flush_o`=1, `idex_flush_o`=1.
- **jr**: `PCSrc`=11, `pc_en_o`=1, `ifid_flush_o`=1.
- **jump**: `PCSrc`=10, `pc_en_o`=1, `ifid_flush_o`=1.
- **Redirect with `imem_ready_i`=0** (any of the three above): set `discard`=1 and go to WAIT_MEM.
- **Redirect with `imem_ready_i`=1**: stay in or go to RUN; `discard`=0.
- **load_use**: `PCSrc`=00, `pc_en_o`=0, `ifid_en_o`=0, `idex_flush_o`=1. State is unchanged.
- **Normal, `imem_ready_i`=1**
  - `discard`=0: `PCSrc`=00, `pc_en_o`=1, `ifid_en_o`=1; go to RUN.
  - `discard`=1: `pc_en_o`=0, `ifid_en_o`=0, `ifid_flush_o`=1; clear `discard`; go to RUN.
- **Normal, `imem_ready_i`=0**: `pc_en_o`=0, `ifid_en_o`=0; go to or stay in WAIT_MEM.
- **Halt**
  - `halt_i` is honoured only when no redirect is active that cycle.
  - In RUN with `imem_ready_i`=1, `halt_i` sends the block to HALTED with enables 0.
  - Otherwise `halt_i` sets `halt_pend`. The next cycle with `imem_ready_i`=1 asserts `ifid_flush_o`=1 and goes to HALTED.
- **HALTED**: `fetch_req_o`=0; all enables and flushes are 0. Only `rst` exits.
- **Counters**: increment by 1 on the qualifying cycle and saturate at all-ones; they never wrap.

## Timing
- Reset values: state BOOT, `PCSrc`=00, `pc_en_o`=0, `ifid_en_o`=0, `ifid_flush_o`=0, `idex_flush_o`=0, `fetch_req_o`=0, counters 0, flags 0.
- `rst` asserted mid-operation clears everything immediately, including a pending `discard` or `halt_pend`.
- First `fetch_req_o`=1 comes `RESET_WAIT` cycles after reset release.
- Redirect penalty:
  - The PC loads the target on the same edge the condition is seen.
  - Branch costs 2 bubbles; jump and jr cost 1.
- Load-use costs exactly 1 bubble per asserted cycle.
- Zero extra latency when `imem_ready_i` is held at 1.
- Simultaneous `load_use_i` and `branch_taken_i`: the branch wins; a single `idex_flush_o` covers both.

## Test plan
- `RESET_WAIT`=2, release `rst`, `imem_ready_i`=1 → `fetch_req_o` rises on cycle 2. `pc_en_o`=1 every cycle after; `stall_cnt_o`=0 after 10 cycles.
- `jump_i` and `branch_taken_i` high in the same cycle → `PCSrc`=01, `ifid_flush_o`=1, `idex_flush_o`=1; `flush_cnt_o` increments by 1.
- `load_use_i` high for 1 cycle → `pc_en_o`=0, `ifid_en_o`=0, `idex_flush_o`=1 for that cycle only; `stall_cnt_o` increments by 1.
- `imem_ready_i` low 3 cycles, `jr_i` on the 2nd, ready on the 4th:
  - `PCSrc`=11 with `pc_en_o`=1 on cycle 2.
  - Cycle 4: `ifid_flush_o`=1, `ifid_en_o`=0.
  - `stall_cnt_o` increments by 3.
- `halt_i` during WAIT_MEM → on ready, `ifid_flush_o`=1; then HALTED with `fetch_req_o`=0. `rst` pulse → BOOT with all outputs 0.
- `CNT_W`=4, 20 consecutive memory-wait cycles → `stall_cnt_o` saturates at 15 and holds.
